// File: rtl/io_port_responder.sv
// io_port_responder: I/O-cycle responder for a four-port block (LED register,
// synchronized switches, scratch register, access counter). Decodes IN/OUT
// cycles, holds the CPU with a programmable number of wait states, then
// completes the transfer.
module io_port_responder #(
  parameter logic [7:0]  BASE_PORT   = 8'h80,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] cpuLowAdr,
  input  logic [7:0] cpuDataOut,
  input  logic       sOUT,
  input  logic       sINP,
  input  logic       pWR_n,
  input  logic       pDBIN,
  input  logic [7:0] portIn,
  output logic [7:0] dataToCpu,
  output logic       dataValid,
  output logic       pReady,
  output logic [7:0] ledReg,
  output logic       ioHit
);

  // The end-of-cycle step is folded into the transition back to idle, so the
  // block is idle again one clock after the status bits drop and a new cycle
  // may start on the very next clock.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE
  } ioState_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  ioState_t    state, stateNext;
  logic [3:0]  waitCnt, waitCntNext;
  logic [1:0]  portIdx, portIdxNext;
  logic        isRead, isReadNext;
  logic        writeDone, writeDoneNext;
  logic [7:0]  scratch, scratchNext;
  logic [7:0]  accessCount, accessCountNext;
  logic [7:0]  ledNext;
  logic [7:0]  dataToCpuNext;
  logic        dataValidNext;
  logic        pReadyNext;
  logic        ioHitNext;

  logic        ioAny, ioAnyD, ioStart, hit;
  logic [7:0]  portSync1, portSync2;
  logic [7:0]  readData;

  assign ioAny   = sINP | sOUT;
  assign ioStart = ioAny & ~ioAnyD;
  // Both status bits high is an illegal cycle and is never decoded.
  assign hit     = ioStart & (cpuLowAdr[7:2] == BASE_PORT[7:2]) & ~(sINP & sOUT);

  // Edge detect on the status bits and two-flop synchronizer for the switches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ioAnyD    <= 1'b0;
      portSync1 <= 8'h00;
      portSync2 <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ioAnyD    <= ioAny;
      portSync1 <= portIn;
      portSync2 <= portSync1;
    end
  end

  // Read-data select for the latched port index.
  always_comb begin
    readData = 8'h00;
    case (portIdx)
      2'd0:    readData = ledReg;
      2'd1:    readData = portSync2;
      2'd2:    readData = scratch;
      default: readData = accessCount;
    endcase
  end

  // Next-state and next-output logic for the cycle sequencer.
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case below can leave one unassigned and infer a latch.
    stateNext       = state;
    waitCntNext     = waitCnt;
    portIdxNext     = portIdx;
    isReadNext      = isRead;
    writeDoneNext   = writeDone;
    scratchNext     = scratch;
    accessCountNext = accessCount;
    ledNext         = ledReg;
    dataToCpuNext   = dataToCpu;
    dataValidNext   = dataValid;
    pReadyNext      = pReady;
    ioHitNext       = ioHit;

    case (state)
      S_IDLE: begin
        if (hit) begin
          portIdxNext   = cpuLowAdr[1:0];
          isReadNext    = sINP;
          writeDoneNext = 1'b0;
          ioHitNext     = 1'b1;
          if (WAIT_INIT == 4'd0) begin
            stateNext = S_ACTIVE;
          end else begin
            stateNext   = S_WAIT;
            waitCntNext = WAIT_INIT;
            pReadyNext  = 1'b0;
          end
        end
      end

      S_WAIT: begin
        if (!ioAny) begin
          // Aborted before the transfer: no data moved, nothing counted.
          stateNext     = S_IDLE;
          ioHitNext     = 1'b0;
          dataValidNext = 1'b0;
          pReadyNext    = 1'b1;
        end else if (waitCnt == 4'd1) begin
          stateNext  = S_ACTIVE;
          pReadyNext = 1'b1;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end

      S_ACTIVE: begin
        if (!ioAny) begin
          stateNext       = S_IDLE;
          ioHitNext       = 1'b0;
          dataValidNext   = 1'b0;
          pReadyNext      = 1'b1;
          accessCountNext = accessCount + 8'd1;
        end else if (isRead) begin
          dataToCpuNext = readData;
          dataValidNext = pDBIN;
        end else begin
          dataValidNext = 1'b0;
          // Only the first write strobe of a cycle lands; ports 1 and 3 are
          // read-only and silently drop the data.
          if (!pWR_n && !writeDone) begin
            writeDoneNext = 1'b1;
            case (portIdx)
              2'd0:    ledNext     = cpuDataOut;
              2'd2:    scratchNext = cpuDataOut;
              default: ;
            endcase
          end
        end
      end

      default: stateNext = S_IDLE;
    endcase
  end

  // Sequencer state, port registers and bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      waitCnt     <= 4'd0;
      portIdx     <= 2'd0;
      isRead      <= 1'b0;
      writeDone   <= 1'b0;
      scratch     <= 8'h00;
      accessCount <= 8'h00;
      ledReg      <= 8'h00;
      dataToCpu   <= 8'h00;
      dataValid   <= 1'b0;
      pReady      <= 1'b1;
      ioHit       <= 1'b0;
    end else begin
      state       <= stateNext;
      waitCnt     <= waitCntNext;
      portIdx     <= portIdxNext;
      isRead      <= isReadNext;
      writeDone   <= writeDoneNext;
      scratch     <= scratchNext;
      accessCount <= accessCountNext;
      ledReg      <= ledNext;
      dataToCpu   <= dataToCpuNext;
      dataValid   <= dataValidNext;
      pReady      <= pReadyNext;
      ioHit       <= ioHitNext;
    end
  end

endmodule
